regfile_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined core. Successor to the single-write 15-entry file.
- Adds configurable width, depth and port counts, plus reset initialisation.
- Writes are posedge with a combinational write-to-read bypass, replacing the negedge write.
- Adds a per-register pending-write scoreboard. ID reserves the destination; WB releases it. Hazard detection uses rd_busy directly.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and elaboration helpers for the multi-port register file.
package regfile_pkg;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 15;

  // R15 is the program counter and is held outside this file.
  localparam int PC_IDX = 15;

  // Number of bits needed to hold the values 0..n.
  function automatic int bits_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: ID reserves a destination, WB releases it.
// Produces the read-side busy flags, the reservation grant and a sticky error.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wb_en,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WR-1:0]        wb_release,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic                     sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DEC_W = bits_for(NUM_WR);
  localparam int SUM_W = max_i(PEND_W, DEC_W) + 1;
  localparam logic [PEND_W-1:0] CNT_MAX    = '1;
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  genvar gi;

  logic [ADDR_W-1:0]   wb_addr_a [NUM_WR];
  logic [NUM_WR-1:0]   rel_v;
  logic [PEND_W-1:0]   avail_ext [DEPTH];
  logic [NUM_REGS-1:0] under_v;
  logic                rsv_in_range;
  logic                rsv_refused;
  logic                sb_err_q;
  logic                sb_err_d;

  for (gi = 0; gi < NUM_WR; gi++) begin : g_wb
    assign wb_addr_a[gi] = wb_addr[gi*ADDR_W +: ADDR_W];
    assign rel_v[gi]     = wb_en[gi] & wb_release[gi];
  end

  // avail = count left after this cycle's releases, clamped at zero; slots
  // beyond NUM_REGS read as zero so out-of-range lookups are never busy.
  for (gi = 0; gi < DEPTH; gi++) begin : g_cnt
    if (gi < NUM_REGS) begin : g_live
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

      logic [PEND_W-1:0] cnt_q;
      logic [PEND_W-1:0] cnt_d;
      logic [DEC_W-1:0]  dec;
      logic [SUM_W-1:0]  cnt_x;
      logic [SUM_W-1:0]  dec_x;
      logic [SUM_W-1:0]  sum_x;
      logic              inc;

      always_comb begin
        dec = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (rel_v[p] && (wb_addr_a[p] == IDX)) begin
            dec = dec + DEC_W'(1);
          end
        end
      end

      assign cnt_x         = SUM_W'(cnt_q);
      assign dec_x         = SUM_W'(dec);
      assign avail_ext[gi] = (cnt_x > dec_x) ? PEND_W'(cnt_x - dec_x) : '0;
      assign under_v[gi]   = (cnt_x < dec_x);
      assign inc           = rsv_en && (rsv_addr == IDX) && rsv_ok;
      assign sum_x         = cnt_x + SUM_W'(inc);

      always_comb begin
        cnt_d = '0;
        if (sum_x >= dec_x) begin
          cnt_d = PEND_W'(sum_x - dec_x);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_pad
      assign avail_ext[gi] = '0;
    end
  end

  for (gi = 0; gi < NUM_RD; gi++) begin : g_busy
    assign rd_busy[gi] = (avail_ext[rd_addr[gi*ADDR_W +: ADDR_W]] != '0);
  end

  assign rsv_in_range = ({1'b0, rsv_addr} < NUM_REGS_X);
  assign rsv_ok       = !(rsv_in_range && (avail_ext[rsv_addr] == CNT_MAX));
  assign rsv_refused  = rsv_en && !rsv_ok;

  always_comb begin
    sb_err_d = sb_err_q | rsv_refused | (|under_v);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file (R0..R14) with posedge write-back,
// same-cycle write-to-read bypass and a pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int PEND_W    = 2,
  parameter int INIT_MODE = INIT_INDEX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wb_en,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WR*DATA_W-1:0] wb_data,
  input  logic [NUM_WR-1:0]        wb_release,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic                     sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  genvar gi;

  logic [ADDR_W-1:0] wb_addr_a [NUM_WR];
  logic [DATA_W-1:0] wb_data_a [NUM_WR];
  logic [NUM_WR-1:0] wb_valid;
  logic [DATA_W-1:0] regs_ext  [DEPTH];

  for (gi = 0; gi < NUM_WR; gi++) begin : g_wb
    assign wb_addr_a[gi] = wb_addr[gi*ADDR_W +: ADDR_W];
    assign wb_data_a[gi] = wb_data[gi*DATA_W +: DATA_W];
    assign wb_valid[gi]  = wb_en[gi] && ({1'b0, wb_addr_a[gi]} < NUM_REGS_X);
  end

  // Storage padded to the full address space with constant zeros so reads
  // of unimplemented addresses need no separate range check.
  for (gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi < NUM_REGS) begin : g_live
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      localparam logic [DATA_W-1:0] RST_VAL =
        (INIT_MODE == INIT_INDEX) ? DATA_W'(gi) : '0;

      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      // Later ports overwrite earlier ones, so the highest index wins.
      always_comb begin
        reg_d = reg_q;
        for (int p = 0; p < NUM_WR; p++) begin
          if (wb_valid[p] && (wb_addr_a[p] == IDX)) begin
            reg_d = wb_data_a[p];
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          reg_q <= RST_VAL;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_ext[gi] = reg_q;
    end else begin : g_pad
      assign regs_ext[gi] = '0;
    end
  end

  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_val;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = regs_ext[addr];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_valid[p] && (wb_addr_a[p] == addr)) begin
          rd_val = wb_data_a[p];
        end
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .PEND_W   (PEND_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_release (wb_release),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_ok     (rsv_ok),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a random phase,
// expectations queued at drive time and compared once outputs settle.
module tb_regfile_mp;

  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 15;
  localparam int ADDR_W    = 4;
  localparam int NUM_RD    = 2;
  localparam int NUM_WR    = 2;
  localparam int PEND_W    = 2;
  localparam int INIT_MODE = 1;
  localparam int CMAX      = (1 << PEND_W) - 1;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_OK   = 2;
  localparam int K_ERR  = 3;

  logic                     clk;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wb_en;
  logic [NUM_WR*ADDR_W-1:0] wb_addr;
  logic [NUM_WR*DATA_W-1:0] wb_data;
  logic [NUM_WR-1:0]        wb_release;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic                     sb_err;

  regfile_mp #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .PEND_W    (PEND_W),
    .INIT_MODE (INIT_MODE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_release (wb_release),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_ok     (rsv_ok),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_regs [16];
  int          m_cnt  [16];
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wa(input int p);
    return int'(wb_addr[p*ADDR_W +: ADDR_W]);
  endfunction

  function automatic logic [31:0] wd(input int p);
    return wb_data[p*DATA_W +: DATA_W];
  endfunction

  function automatic int m_dec(input int r);
    int n = 0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wb_en[p] && wb_release[p] && wa(p) == r && r < NUM_REGS) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] m_rd(input int a);
    logic [31:0] v = (a < NUM_REGS) ? m_regs[a] : 32'h0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wb_en[p] && wa(p) == a && a < NUM_REGS) v = wd(p);
    end
    return v;
  endfunction

  function automatic int m_avail(input int a);
    int d;
    if (a >= NUM_REGS) return 0;
    d = m_dec(a);
    return (m_cnt[a] > d) ? m_cnt[a] - d : 0;
  endfunction

  function automatic bit m_rsv_ok();
    int a = int'(rsv_addr);
    if (a >= NUM_REGS) return 1'b1;
    return m_avail(a) != CMAX;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = (r < NUM_REGS && INIT_MODE == 1) ? 32'(r) : 32'h0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_clock();
    int nxt [16];
    bit ok = m_rsv_ok();
    for (int r = 0; r < 16; r++) begin
      int inc = (rsv_en && int'(rsv_addr) == r && r < NUM_REGS && ok) ? 1 : 0;
      int d   = m_dec(r);
      if (m_cnt[r] < d) m_err = 1'b1;
      nxt[r] = m_cnt[r] + inc - d;
      if (nxt[r] < 0) nxt[r] = 0;
    end
    if (rsv_en && int'(rsv_addr) < NUM_REGS && !ok) m_err = 1'b1;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wb_en[p] && wa(p) < NUM_REGS) m_regs[wa(p)] = wd(p);
    end
    for (int r = 0; r < 16; r++) m_cnt[r] = nxt[r];
  endtask

  task automatic push(input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_model();
    for (int k = 0; k < NUM_RD; k++) begin
      int a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
      push(K_DATA, k, m_rd(a));
      push(K_BUSY, k, 32'(m_avail(a) != 0));
    end
    push(K_OK, 0, 32'(m_rsv_ok()));
    push(K_ERR, 0, 32'(m_err));
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    string       tag;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_DATA: begin obs = rd_data[e.idx*DATA_W +: DATA_W]; tag = $sformatf("rd_data%0d", e.idx); end
        K_BUSY: begin obs = 32'(rd_busy[e.idx]);             tag = $sformatf("rd_busy%0d", e.idx); end
        K_OK:   begin obs = 32'(rsv_ok);                     tag = "rsv_ok"; end
        default: begin obs = 32'(sb_err);                    tag = "sb_err"; end
      endcase
      chk(tag, obs, e.val);
    end
  endtask

  // One transaction: queue expectations, compare after settling, then clock.
  task automatic cycle();
    push_model();
    #1;
    drain();
    $display("txn t=%0t rst=%b wb_en=%b rel=%b wb_addr=%h rsv=%b@%0d rd_addr=%h rd_data=%h busy=%b ok=%b err=%b",
             $time, rst, wb_en, wb_release, wb_addr, rsv_en, rsv_addr, rd_addr, rd_data, rd_busy, rsv_ok, sb_err);
    @(posedge clk);
    if (rst) m_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en      = '0;
    wb_release = '0;
    rsv_en     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    m_reset();
    cycle();
    rst = 1'b1;
  endtask

  function automatic logic [3:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    rst      = 1'b0;
    idle();
    rd_addr  = {4'd14, 4'd3};
    wb_addr  = '0;
    wb_data  = '0;
    rsv_addr = '0;
    m_reset();
    @(negedge clk);

    // Reset state with index initialisation.
    push(K_DATA, 0, 32'd3);
    push(K_DATA, 1, 32'd14);
    push(K_BUSY, 0, 32'd0);
    push(K_ERR, 0, 32'd0);
    cycle();
    rst = 1'b1;
    cycle();

    // Single write with same-cycle bypass, then stored value.
    wb_en = 2'b01; wb_addr = {4'd0, 4'd5}; wb_data = {32'h0, 32'hDEADBEEF}; rd_addr = {4'd7, 4'd5};
    push(K_DATA, 0, 32'hDEADBEEF);
    cycle();
    idle();
    push(K_DATA, 0, 32'hDEADBEEF);
    cycle();

    // Two ports hit the same register: higher port wins, also on the bypass.
    wb_en = 2'b11; wb_addr = {4'd7, 4'd7}; wb_data = {32'h22, 32'h11}; rd_addr = {4'd5, 4'd7};
    push(K_DATA, 0, 32'h22);
    cycle();
    idle();
    push(K_DATA, 0, 32'h22);
    cycle();

    // Out-of-range write is ignored and out-of-range read is zero.
    wb_en = 2'b10; wb_addr = {4'd15, 4'd0}; wb_data = {32'hBAD0BAD0, 32'h0}; rd_addr = {4'd15, 4'd15};
    push(K_DATA, 0, 32'h0);
    cycle();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd15;
    push(K_OK, 0, 32'd1);
    cycle();

    // Fill r2 to the counter limit, then a refused fourth reservation.
    rd_addr = {4'd2, 4'd0};
    for (int i = 0; i < 3; i++) begin
      idle(); rsv_en = 1'b1; rsv_addr = 4'd2;
      cycle();
    end
    push(K_BUSY, 1, 32'd1);
    push(K_OK, 0, 32'd0);
    cycle();
    idle();
    push(K_ERR, 0, 32'd1);
    push(K_BUSY, 1, 32'd1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      wb_en = 2'b01; wb_release = 2'b01; wb_addr = {4'd0, 4'd2}; wb_data = {32'h0, 32'(i + 100)};
      push(K_BUSY, 1, (i == 2) ? 32'd0 : 32'd1);
      cycle();
    end
    idle();
    push(K_BUSY, 1, 32'd0);
    cycle();

    // Reserve and release r4 together, then underflow on r9.
    do_reset();
    rd_addr = {4'd9, 4'd4};
    rsv_en = 1'b1; rsv_addr = 4'd4;
    cycle();
    wb_en = 2'b01; wb_release = 2'b01; wb_addr = {4'd0, 4'd4}; wb_data = {32'h0, 32'h44};
    cycle();
    idle();
    push(K_BUSY, 0, 32'd1);
    push(K_ERR, 0, 32'd0);
    cycle();
    wb_en = 2'b01; wb_release = 2'b01; wb_addr = {4'd0, 4'd9}; wb_data = {32'h0, 32'h99};
    cycle();
    idle();
    push(K_DATA, 1, 32'h99);
    push(K_ERR, 0, 32'd1);
    cycle();

    // Asynchronous reset mid-flight with r2 pending twice and r5 written.
    do_reset();
    rd_addr = {4'd2, 4'd5};
    for (int i = 0; i < 2; i++) begin
      idle(); rsv_en = 1'b1; rsv_addr = 4'd2;
      cycle();
    end
    idle();
    wb_en = 2'b01; wb_addr = {4'd0, 4'd5}; wb_data = {32'h0, 32'hDEADBEEF};
    cycle();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd2;
    push(K_BUSY, 1, 32'd1);
    push(K_DATA, 0, 32'hDEADBEEF);
    #3;
    drain();
    rst = 1'b0;
    m_reset();
    push(K_BUSY, 1, 32'd0);
    push(K_DATA, 0, 32'd5);
    push(K_ERR, 0, 32'd0);
    cycle();
    idle();
    rst = 1'b1;
    cycle();

    // Random traffic concentrated on a few registers to stress the counters.
    for (int n = 0; n < 300; n++) begin
      wb_en      = 2'($urandom);
      wb_release = 2'($urandom);
      wb_addr    = {rnd_addr(), rnd_addr()};
      wb_data    = {32'($urandom), 32'($urandom)};
      rd_addr    = {rnd_addr(), rnd_addr()};
      rsv_en     = 1'($urandom);
      rsv_addr   = rnd_addr();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
